// File: rtl/fib_sched_pkg.sv
// Shared types and helpers for the Fibonacci job scheduler.
// Holds the FSM state encoding, default widths and the round-robin pick function.
package fib_sched_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StResp
    } state_e;

    localparam int unsigned DefDataW = 9;
    localparam int unsigned DefIdxW  = 6;
    localparam int unsigned MaxReq   = 32;

    // First set bit scanning upward from last+1, wrapping at nreq.
    // Returns last when no bit is set; callers qualify the result with |req.
    function automatic int unsigned rr_pick(input logic [MaxReq-1:0] req,
                                            input int unsigned       last,
                                            input int unsigned       nreq);
        int unsigned idx;
        logic        found;
        rr_pick = last;
        found   = 1'b0;
        for (int unsigned i = 1; i <= MaxReq; i++) begin
            idx = last + i;
            if (idx >= nreq) idx = idx - nreq;
            if (i <= nreq && !found && req[idx[4:0]]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/fib_job_sched_if.sv
// Client-side bundle of the Fibonacci job scheduler: requests, grants and result handshake.
// The scheduler uses the slave modport, clients the master modport.
interface fib_job_sched_if #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned DATA_W = 9,
    parameter int unsigned IDX_W  = 6
);
    localparam int unsigned IdW = $clog2(NREQ);

    logic [NREQ-1:0]       req;
    logic [NREQ*IDX_W-1:0] req_idx;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic                  rsp_valid;
    logic [IdW-1:0]        rsp_id;
    logic [DATA_W-1:0]     rsp_data;
    logic                  rsp_ovf;
    logic                  rsp_ready;

    modport master (
        output req, req_idx, rsp_ready,
        input  gnt, busy, rsp_valid, rsp_id, rsp_data, rsp_ovf
    );

    modport slave (
        input  req, req_idx, rsp_ready,
        output gnt, busy, rsp_valid, rsp_id, rsp_data, rsp_ovf
    );
endinterface

// File: rtl/fib_step_core.sv
// Fibonacci step engine: a/b pair with sticky overflow tracking per term.
// load initialises (a,b) = (F0,F1); each step advances one index, mod 2^DATA_W.
module fib_step_core #(
    parameter int unsigned DATA_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    output logic [DATA_W-1:0] a,
    output logic              ovf_a
);
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic              ovf_a_q, ovf_a_d, ovf_b_q, ovf_b_d;
    logic [DATA_W:0]   sum;

    assign sum = {1'b0, a_q} + {1'b0, b_q};

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        ovf_a_d = ovf_a_q;
        ovf_b_d = ovf_b_q;
        if (load) begin
            a_d     = '0;
            b_d     = DATA_W'(1);
            ovf_a_d = 1'b0;
            ovf_b_d = 1'b0;
        end else if (step) begin
            a_d     = b_q;
            b_d     = sum[DATA_W-1:0];
            ovf_a_d = ovf_b_q;
            // A term overflows if its own add carried or either predecessor already had.
            ovf_b_d = sum[DATA_W] | ovf_a_q | ovf_b_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= DATA_W'(1);
            ovf_a_q <= 1'b0;
            ovf_b_q <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            ovf_a_q <= ovf_a_d;
            ovf_b_q <= ovf_b_d;
        end
    end

    assign a     = a_q;
    assign ovf_a = ovf_a_q;
endmodule

// File: rtl/fib_job_sched.sv
// Round-robin scheduler sharing one Fibonacci step engine between NREQ requesters.
// All outputs except gnt come from registers; gnt decodes IDLE state plus req.
module fib_job_sched
    import fib_sched_pkg::*;
#(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned IDX_W  = DefIdxW
) (
    input logic          clk,
    input logic          rst,
    fib_job_sched_if.slave bus
);
    localparam int unsigned IdW = $clog2(NREQ);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic [IdW-1:0]    id_q, id_d;
    logic [IdW-1:0]    rr_last_q, rr_last_d;
    logic              busy_q, busy_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [IdW-1:0]    rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_ovf_q, rsp_ovf_d;

    logic [NREQ-1:0]   gnt_c;
    logic [IdW-1:0]    win;
    logic [IDX_W-1:0]  idx_arr [NREQ];
    logic              eng_load, eng_step;
    logic [DATA_W-1:0] eng_a;
    logic              eng_ovf_a;

    always_comb begin
        for (int i = 0; i < NREQ; i++) idx_arr[i] = bus.req_idx[i*IDX_W +: IDX_W];
    end

    assign win = IdW'(rr_pick(MaxReq'(bus.req), 32'(rr_last_q), NREQ));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        id_d       = id_q;
        rr_last_d  = rr_last_q;
        rsp_id_d   = rsp_id_q;
        rsp_data_d = rsp_data_q;
        rsp_ovf_d  = rsp_ovf_q;
        gnt_c      = '0;
        eng_load   = 1'b0;
        eng_step   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (|bus.req) begin
                    gnt_c     = NREQ'(1) << win;
                    rr_last_d = win;
                    id_d      = win;
                    cnt_d     = idx_arr[win];
                    eng_load  = 1'b1;
                    state_d   = StRun;
                end
            end
            StRun: begin
                if (cnt_q != '0) begin
                    eng_step = 1'b1;
                    cnt_d    = cnt_q - IDX_W'(1);
                end else begin
                    // Engine is idle on this edge, so a/ovf_a already hold F(n).
                    state_d    = StResp;
                    rsp_data_d = eng_a;
                    rsp_ovf_d  = eng_ovf_a;
                    rsp_id_d   = id_q;
                end
            end
            StResp: begin
                if (bus.rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        busy_d      = (state_d != StIdle);
        rsp_valid_d = (state_d == StResp);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            id_q        <= '0;
            rr_last_q   <= IdW'(NREQ - 1);
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            id_q        <= id_d;
            rr_last_q   <= rr_last_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_ovf_q   <= rsp_ovf_d;
        end
    end

    fib_step_core #(
        .DATA_W(DATA_W)
    ) u_core (
        .clk  (clk),
        .rst  (rst),
        .load (eng_load),
        .step (eng_step),
        .a    (eng_a),
        .ovf_a(eng_ovf_a)
    );

    assign bus.gnt       = gnt_c;
    assign bus.busy      = busy_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_ovf   = rsp_ovf_q;
endmodule

// File: tb/tb_fib_job_sched.sv
// Self-checking bench for fib_job_sched: directed scenarios plus random jobs
// checked against a 64-bit Fibonacci reference model.
module tb_fib_job_sched;
    localparam int unsigned NREQ   = 4;
    localparam int unsigned DATA_W = 9;
    localparam int unsigned IDX_W  = 6;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    fib_job_sched_if #(.NREQ(NREQ), .DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

    fib_job_sched #(
        .NREQ  (NREQ),
        .DATA_W(DATA_W),
        .IDX_W (IDX_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint unsigned fib_ref(input int n);
        longint unsigned x, y, t;
        x = 0;
        y = 1;
        for (int i = 0; i < n; i++) begin
            t = x + y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int r, input int n);
        bus.req = '0;
        bus.req[r] = 1'b1;
        bus.req_idx[r*IDX_W +: IDX_W] = IDX_W'(n);
    endtask

    // Single job from requester r with index n; checks grant, latency, result and handshake.
    task automatic run_job(input int r, input int n);
        longint unsigned f;
        logic [63:0]     fx;
        logic [NREQ-1:0] g_exp;
        int              lat;
        f = fib_ref(n);
        fx = f;
        g_exp = '0;
        g_exp[r] = 1'b1;
        set_req(r, n);
        #1;
        chk("gnt", 64'(bus.gnt), 64'(g_exp));
        chk("busy_idle", 64'(bus.busy), 0);
        tick();
        bus.req = '0;
        lat = 1;
        while (!bus.rsp_valid && lat < 100) begin
            tick();
            lat++;
        end
        chk("latency", 64'(lat), 64'(n + 2));
        chk("data", 64'(bus.rsp_data), 64'(fx[DATA_W-1:0]));
        chk("ovf", 64'(bus.rsp_ovf), 64'(f >= 64'(1 << DATA_W)));
        chk("id", 64'(bus.rsp_id), 64'(r));
        chk("busy_resp", 64'(bus.busy), 1);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk("valid_drop", 64'(bus.rsp_valid), 0);
        chk("busy_drop", 64'(bus.busy), 0);
    endtask

    // Waits for the next grant with req held and returns the winning index (-1 on timeout).
    task automatic collect(output int w);
        int k;
        w = -1;
        k = 0;
        while (k < 200 && w < 0) begin
            #1;
            if (bus.gnt != '0) begin
                chk("gnt_onehot", 64'($onehot(bus.gnt)), 1);
                for (int i = 0; i < NREQ; i++) if (bus.gnt[i]) w = i;
            end
            tick();
            k++;
        end
    endtask

    initial begin
        int              w;
        int              seen;
        int              k;
        int              exp_order[8];
        longint unsigned f;
        logic [63:0]     fx;

        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        bus.req = '0;
        bus.req_idx = '0;
        bus.rsp_ready = 1'b0;
        tick();
        tick();
        chk("rst_busy", 64'(bus.busy), 0);
        chk("rst_valid", 64'(bus.rsp_valid), 0);
        chk("rst_id", 64'(bus.rsp_id), 0);
        chk("rst_data", 64'(bus.rsp_data), 0);
        chk("rst_ovf", 64'(bus.rsp_ovf), 0);
        chk("rst_gnt", 64'(bus.gnt), 0);
        rst = 1'b0;
        tick();

        // Directed single jobs, including overflow boundary around F(14)/F(15).
        run_job(0, 10);
        run_job(1, 0);
        run_job(2, 1);
        run_job(3, 14);
        run_job(0, 15);
        run_job(1, 13);
        run_job(2, 63);

        // Backpressure: result held 20 cycles while another request waits.
        set_req(0, 5);
        tick();
        bus.req = '0;
        k = 0;
        while (!bus.rsp_valid && k < 100) begin
            tick();
            k++;
        end
        set_req(2, 0);
        for (int i = 0; i < 20; i++) begin
            chk("bp_valid", 64'(bus.rsp_valid), 1);
            chk("bp_data", 64'(bus.rsp_data), 5);
            chk("bp_id", 64'(bus.rsp_id), 0);
            chk("bp_gnt", 64'(bus.gnt), 0);
            tick();
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk("hs_gnt", 64'(bus.gnt), 0);
        tick();
        bus.rsp_ready = 1'b0;
        chk("hs_valid", 64'(bus.rsp_valid), 0);
        chk("post_hs_gnt", 64'(bus.gnt), 64'(4'b0100));
        tick();
        bus.req = '0;
        k = 0;
        while (!bus.rsp_valid && k < 100) begin
            tick();
            k++;
        end
        chk("bp2_id", 64'(bus.rsp_id), 2);
        chk("bp2_data", 64'(bus.rsp_data), 0);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;

        // Reset in the middle of a long job.
        set_req(1, 20);
        tick();
        bus.req = '0;
        for (int i = 0; i < 4; i++) tick();
        chk("mid_busy", 64'(bus.busy), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 64'(bus.busy), 0);
        chk("mid_rst_valid", 64'(bus.rsp_valid), 0);
        chk("mid_rst_data", 64'(bus.rsp_data), 0);
        chk("mid_rst_id", 64'(bus.rsp_id), 0);
        tick();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus.rsp_valid) seen++;
            tick();
        end
        chk("no_rsp_after_rst", 64'(seen), 0);
        bus.req = 4'b1111;
        #1;
        chk("rr_restart", 64'(bus.gnt), 64'(4'b0001));
        bus.req = '0;
        tick();
        chk("dropped_req", 64'(bus.busy), 0);

        // Round-robin fairness with requests held, then a reduced request set.
        exp_order = '{0, 1, 2, 3, 0, 1, 3, 1};
        for (int i = 0; i < NREQ; i++) bus.req_idx[i*IDX_W +: IDX_W] = IDX_W'(3);
        bus.req = 4'b1111;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            collect(w);
            chk("rr_order", 64'(w), 64'(exp_order[i]));
            if (i == 5) bus.req = 4'b1010;
        end
        bus.req = '0;
        k = 0;
        while (bus.busy && k < 100) begin
            tick();
            k++;
        end
        bus.rsp_ready = 1'b0;
        chk("rr_idle", 64'(bus.busy), 0);

        // Random jobs against the reference model.
        for (int i = 0; i < 14; i++) begin
            run_job(int'($urandom_range(0, NREQ - 1)), int'($urandom_range(0, 63)));
        end

        f = fib_ref(15);
        fx = f;
        chk("model_sanity_f15", 64'(fx[DATA_W-1:0]), 64'(98));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
